// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the stage registers.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_e;

    // Canonical RV32 NOP (addi x0,x0,0) and the all-zero control bubble.
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [7:0]  BUBBLE_CTRL  = 8'h00;

    // Nonzero destination register that matches a used source operand.
    function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs, input logic use_rs);
        rd_hit = use_rs & (rd != 5'd0) & (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous clear; used for the HAZARD_PERF_EN statistics.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline load/hold/bubble controller for the 5-stage RV32 core.
// Define HAZARD_PERF_EN to add the loadUseCnt/mdStallCnt/flushCnt statistics outputs.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             useRS1_ID,
    input  logic             useRS2_ID,
    input  logic [4:0]       RD_EX,
    input  logic             memRead_EX,
    input  logic             mdOp_EX,
    input  logic             branchTaken_EX,
    input  logic             memWait_MEM,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] loadUseCnt,
    output logic [CNT_W-1:0] mdStallCnt,
    output logic [CNT_W-1:0] flushCnt,
`endif
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexWrite,
    output logic             idexFlush,
    output logic             exmemWrite,
    output logic             exmemFlush,
    output logic             memwbWrite,
    output logic             mdBusy
);

    localparam int MDC_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [MDC_W-1:0] MD_RELOAD = MDC_W'((MD_LAT >= 2) ? (MD_LAT - 2) : 0);
    localparam logic MD_EN = (MD_LAT >= 2) ? 1'b1 : 1'b0;

    hz_state_e        state_r;
    hz_state_e        state_nxt_s;
    logic [MDC_W-1:0] md_cnt_r;
    logic [MDC_W-1:0] md_cnt_nxt_s;
    logic             load_use_s;

    assign load_use_s = memRead_EX & (rd_hit(RD_EX, RS1_ID, useRS1_ID) | rd_hit(RD_EX, RS2_ID, useRS2_ID));

    // Mealy decode of stage enables and next state; priority reset > memWait > branch > MD > load-use.
    always_comb begin
        pcWrite      = 1'b1;
        ifidWrite    = 1'b1;
        ifidFlush    = 1'b0;
        idexWrite    = 1'b1;
        idexFlush    = 1'b0;
        exmemWrite   = 1'b1;
        exmemFlush   = 1'b0;
        memwbWrite   = 1'b1;
        mdBusy       = 1'b0;
        state_nxt_s  = state_r;
        md_cnt_nxt_s = md_cnt_r;
        if (RST) begin
            pcWrite      = 1'b0;
            ifidWrite    = 1'b0;
            idexWrite    = 1'b0;
            exmemWrite   = 1'b0;
            memwbWrite   = 1'b0;
            ifidFlush    = 1'b1;
            idexFlush    = 1'b1;
            exmemFlush   = 1'b1;
            state_nxt_s  = RUN;
            md_cnt_nxt_s = '0;
        end else if (memWait_MEM) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbWrite = 1'b0;
            mdBusy     = (state_r == MD_BUSY) ? 1'b1 : 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (branchTaken_EX) begin
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                    end else if (MD_EN && mdOp_EX) begin
                        pcWrite      = 1'b0;
                        ifidWrite    = 1'b0;
                        idexWrite    = 1'b0;
                        exmemFlush   = 1'b1;
                        mdBusy       = 1'b1;
                        state_nxt_s  = MD_BUSY;
                        md_cnt_nxt_s = MD_RELOAD;
                    end else if (load_use_s) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        idexFlush = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MD_BUSY: begin
                    mdBusy = 1'b1;
                    if (md_cnt_r != '0) begin
                        pcWrite      = 1'b0;
                        ifidWrite    = 1'b0;
                        idexWrite    = 1'b0;
                        exmemFlush   = 1'b1;
                        md_cnt_nxt_s = md_cnt_r - MDC_W'(1);
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s  = RUN;
                    md_cnt_nxt_s = '0;
                end
            endcase
        end
    end

    // State and MD occupancy counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= RUN;
            md_cnt_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
        end
    end

`ifdef HAZARD_PERF_EN
    logic ev_lu_s;
    logic ev_md_s;
    logic ev_fl_s;

    // An event counts only when it is the cause of this cycle's stall or flush.
    assign ev_lu_s = ~RST & ~memWait_MEM & (state_r == RUN) & ~branchTaken_EX
                   & ~(MD_EN & mdOp_EX) & load_use_s;
    assign ev_md_s = ~RST & ~memWait_MEM & mdBusy & ~pcWrite;
    assign ev_fl_s = ~RST & ~memWait_MEM & ifidFlush;

    hazard_perf_cnt #(.W(CNT_W)) u_lu_cnt (.CLK(CLK), .clr(RST), .inc(ev_lu_s), .cnt(loadUseCnt));
    hazard_perf_cnt #(.W(CNT_W)) u_md_cnt (.CLK(CLK), .clr(RST), .inc(ev_md_s), .cnt(mdStallCnt));
    hazard_perf_cnt #(.W(CNT_W)) u_fl_cnt (.CLK(CLK), .clr(RST), .inc(ev_fl_s), .cnt(flushCnt));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MD_LAT=4, CNT_W=4): stimulus pushes expected vectors, monitor compares.
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] RS1_ID = 5'd0, RS2_ID = 5'd0, RD_EX = 5'd0;
    logic       useRS1_ID = 1'b0, useRS2_ID = 1'b0;
    logic       memRead_EX = 1'b0, mdOp_EX = 1'b0, branchTaken_EX = 1'b0, memWait_MEM = 1'b0;
    logic       pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush;
    logic       exmemWrite, exmemFlush, memwbWrite, mdBusy;
`ifdef HAZARD_PERF_EN
    logic [3:0] loadUseCnt, mdStallCnt, flushCnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    // Output vector order: pc, ifidW, ifidF, idexW, idexF, exmemW, exmemF, memwbW, mdBusy
    localparam logic [8:0] E_RST  = 9'b001010100;
    localparam logic [8:0] E_IDLE = 9'b110101010;
    localparam logic [8:0] E_LU   = 9'b000111010;
    localparam logic [8:0] E_BR   = 9'b111111010;
    localparam logic [8:0] E_MDS  = 9'b000001111;
    localparam logic [8:0] E_MDR  = 9'b110101011;
    localparam logic [8:0] E_WT   = 9'b000000000;
    localparam logic [8:0] E_WTMD = 9'b000000001;

    hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .useRS1_ID(useRS1_ID), .useRS2_ID(useRS2_ID),
        .RD_EX(RD_EX), .memRead_EX(memRead_EX), .mdOp_EX(mdOp_EX),
        .branchTaken_EX(branchTaken_EX), .memWait_MEM(memWait_MEM),
`ifdef HAZARD_PERF_EN
        .loadUseCnt(loadUseCnt), .mdStallCnt(mdStallCnt), .flushCnt(flushCnt),
`endif
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .idexWrite(idexWrite), .idexFlush(idexFlush), .exmemWrite(exmemWrite),
        .exmemFlush(exmemFlush), .memwbWrite(memwbWrite), .mdBusy(mdBusy)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic rst, input logic mw, input logic br, input logic md,
                        input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [8:0] e);
        @(posedge CLK);
        #1;
        RST = rst; memWait_MEM = mw; branchTaken_EX = br; mdOp_EX = md; memRead_EX = mr;
        RD_EX = rd; RS1_ID = rs1; useRS1_ID = u1; RS2_ID = rs2; useRS2_ID = u2;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [8:0] e);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, e);
    endtask

    task automatic md_cyc(input logic mw, input logic [8:0] e);
        step(1'b0, mw, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, e);
    endtask

    // Monitor: compare the combinational outputs mid-cycle against the oldest expectation.
    always @(negedge CLK) begin
        logic [8:0] got;
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush,
                   exmemWrite, exmemFlush, memwbWrite, mdBusy};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ctrl t=%0t got=%b expected=%b", $time, got, e);
            end
        end
    end

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
                 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), E_RST);
        end
        idle(E_IDLE);

        // Load-use via rs2, one bubble only
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, E_LU);
        idle(E_IDLE);
        // RD_EX = x0 never stalls
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, E_IDLE);
        // Load-use via rs1
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd3, 1'b1, E_LU);
        // Match but operand not used
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, E_IDLE);
        // Match but EX is not a load
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 5'd3, 1'b0, E_IDLE);

        // Branch beats load-use
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, E_BR);
        idle(E_IDLE);

        // Single MD op: 3 stalls then release
        md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDR);
        idle(E_IDLE);

        // Back-to-back MD ops
        for (int k = 0; k < 2; k++) begin
            md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDR);
        end
        idle(E_IDLE);

        // memWait for 2 cycles at mdCnt=1 freezes the counter
        md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDS);
        md_cyc(1'b1, E_WTMD); md_cyc(1'b1, E_WTMD);
        md_cyc(1'b0, E_MDS); md_cyc(1'b0, E_MDR);
        idle(E_IDLE);

        // memWait in RUN overrides load-use and branch
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, E_WT);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_WT);
        idle(E_IDLE);

        // Reset mid-MD aborts the operation
        md_cyc(1'b0, E_MDS);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, E_RST);
        idle(E_IDLE);
        idle(E_IDLE);

`ifdef HAZARD_PERF_EN
        // 20 load-use events saturate a 4-bit counter at 15
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_RST);
        for (int n = 0; n < 20; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, E_LU);
        end
        idle(E_IDLE);
        @(negedge CLK);
        checks++;
        if (loadUseCnt !== 4'd15) begin
            errors++;
            $display("FAIL perf_sat got=%0d expected=15", loadUseCnt);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_RST);
        idle(E_IDLE);
        @(negedge CLK);
        checks++;
        if (loadUseCnt !== 4'd0) begin
            errors++;
            $display("FAIL perf_clr got=%0d expected=0", loadUseCnt);
        end
`endif

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
            @(posedge CLK);
        end
        #6;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
